calc_port_scheduler: RTL and testbench

- Front-end controller that shares one calculator ALU among four requester ports.
- Each port uses the two-cycle calc request protocol: the cmd cycle carries operand 1, and the following cycle carries operand 2.
- The block captures each port's request, arbitrates round-robin among pending ports, and dispatches one operation at a time to the ALU.
- It routes the ALU result and response code back to the originating port's out_resp/out_data.

---
 rtl/calc_port_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_calc_port_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_scheduler.sv
// Shares one calculator ALU among four two-cycle request ports using round-robin arbitration.
// Each port FSM captures its operands, waits for a grant, and presents the ALU result for one cycle.
//
// Port FSM     | meaning
// P_IDLE       | waiting for a nonzero cmd (op1 captured with it)
// P_OP2        | capturing op2; invalid cmds short-circuit to P_RESP
// P_PEND       | operands held, waiting for dispatcher grant
// P_WAIT       | dispatched, waiting for ALU completion or timeout
// P_RESP       | response visible on outN_resp/outN_data for one cycle
//
// Dispatcher   | meaning
// D_IDLE       | no operation outstanding; grants the next PEND port
// D_BUSY       | one operation outstanding; counting toward TIMEOUT
module calc_port_scheduler #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              c_clk,
   input  logic              reset,
   input  logic [3:0]        req1_cmd_in,
   input  logic [3:0]        req2_cmd_in,
   input  logic [3:0]        req3_cmd_in,
   input  logic [3:0]        req4_cmd_in,
   input  logic [DATA_W-1:0] req1_data_in,
   input  logic [DATA_W-1:0] req2_data_in,
   input  logic [DATA_W-1:0] req3_data_in,
   input  logic [DATA_W-1:0] req4_data_in,
   output logic [1:0]        out1_resp,
   output logic [1:0]        out2_resp,
   output logic [1:0]        out3_resp,
   output logic [1:0]        out4_resp,
   output logic [DATA_W-1:0] out1_data,
   output logic [DATA_W-1:0] out2_data,
   output logic [DATA_W-1:0] out3_data,
   output logic [DATA_W-1:0] out4_data,
   output logic              alu_valid,
   output logic [3:0]        alu_cmd,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   input  logic              alu_done,
   input  logic [1:0]        alu_resp,
   input  logic [DATA_W-1:0] alu_result
);

   typedef enum logic [2:0] {P_IDLE, P_OP2, P_PEND, P_WAIT, P_RESP} port_state_e;
   typedef enum logic       {D_IDLE, D_BUSY} disp_state_e;

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   function automatic logic cmd_ok(input logic [3:0] c);
      return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
   endfunction

   logic [3:0]        cmd_in  [4];
   logic [DATA_W-1:0] data_in [4];

   assign cmd_in[0]  = req1_cmd_in;
   assign cmd_in[1]  = req2_cmd_in;
   assign cmd_in[2]  = req3_cmd_in;
   assign cmd_in[3]  = req4_cmd_in;
   assign data_in[0] = req1_data_in;
   assign data_in[1] = req2_data_in;
   assign data_in[2] = req3_data_in;
   assign data_in[3] = req4_data_in;

   port_state_e       pst_q    [4];
   port_state_e       pst_d    [4];
   logic [3:0]        pcmd_q   [4];
   logic [3:0]        pcmd_d   [4];
   logic [DATA_W-1:0] pop1_q   [4];
   logic [DATA_W-1:0] pop1_d   [4];
   logic [DATA_W-1:0] pop2_q   [4];
   logic [DATA_W-1:0] pop2_d   [4];
   logic [1:0]        prcode_q [4];
   logic [1:0]        prcode_d [4];
   logic [DATA_W-1:0] prdata_q [4];
   logic [DATA_W-1:0] prdata_d [4];

   disp_state_e       dst_q, dst_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        acmd_q, acmd_d;
   logic [DATA_W-1:0] aop1_q, aop1_d;
   logic [DATA_W-1:0] aop2_q, aop2_d;

   logic              grant_v;
   logic [1:0]        grant_idx;
   logic              cpl_v;
   logic [1:0]        cpl_code;
   logic [DATA_W-1:0] cpl_data;

   // Scan downward so the closest PEND port at or after the pointer wins.
   always_comb begin : grant_search
      logic [1:0] idx;
      idx       = '0;
      grant_v   = 1'b0;
      grant_idx = ptr_q;
      if (dst_q == D_IDLE) begin
         for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (pst_q[idx] == P_PEND) begin
               grant_v   = 1'b1;
               grant_idx = idx;
            end
         end
      end
   end

   always_comb begin : disp_next
      dst_d     = dst_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      acmd_d    = acmd_q;
      aop1_d    = aop1_q;
      aop2_d    = aop2_q;
      alu_valid = 1'b0;
      cpl_v     = 1'b0;
      cpl_code  = 2'd0;
      cpl_data  = '0;
      case (dst_q)
         D_IDLE: begin
            if (grant_v) begin
               alu_valid = 1'b1;
               gnt_d     = grant_idx;
               ptr_d     = grant_idx + 2'd1;
               cnt_d     = '0;
               acmd_d    = pcmd_q[grant_idx];
               aop1_d    = pop1_q[grant_idx];
               aop2_d    = pop2_q[grant_idx];
               dst_d     = D_BUSY;
            end
         end
         D_BUSY: begin
            if (alu_done) begin
               cpl_v    = 1'b1;
               cpl_code = alu_resp;
               cpl_data = alu_result;
               dst_d    = D_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  cpl_v    = 1'b1;
                  cpl_code = 2'd3;
                  dst_d    = D_IDLE;
               end
            end
         end
         default: dst_d = D_IDLE;
      endcase
   end

   // The _d copies already carry the granted operands in the dispatch cycle.
   assign alu_cmd = acmd_d;
   assign alu_op1 = aop1_d;
   assign alu_op2 = aop2_d;

   always_comb begin : port_next
      for (int i = 0; i < 4; i++) begin
         pst_d[i]    = pst_q[i];
         pcmd_d[i]   = pcmd_q[i];
         pop1_d[i]   = pop1_q[i];
         pop2_d[i]   = pop2_q[i];
         prcode_d[i] = prcode_q[i];
         prdata_d[i] = prdata_q[i];
         case (pst_q[i])
            P_IDLE: begin
               if (cmd_in[i] != 4'd0) begin
                  pcmd_d[i] = cmd_in[i];
                  pop1_d[i] = data_in[i];
                  pst_d[i]  = P_OP2;
               end
            end
            P_OP2: begin
               pop2_d[i] = data_in[i];
               if (cmd_ok(pcmd_q[i])) begin
                  pst_d[i] = P_PEND;
               end else begin
                  prcode_d[i] = 2'd2;
                  prdata_d[i] = '0;
                  pst_d[i]    = P_RESP;
               end
            end
            P_PEND: begin
               if (grant_v && (grant_idx == 2'(i))) pst_d[i] = P_WAIT;
            end
            P_WAIT: begin
               if (cpl_v && (gnt_q == 2'(i))) begin
                  prcode_d[i] = cpl_code;
                  prdata_d[i] = cpl_data;
                  pst_d[i]    = P_RESP;
               end
            end
            P_RESP:  pst_d[i] = P_IDLE;
            default: pst_d[i] = P_IDLE;
         endcase
      end
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         dst_q  <= D_IDLE;
         ptr_q  <= 2'd0;
         gnt_q  <= 2'd0;
         cnt_q  <= '0;
         acmd_q <= 4'd0;
         aop1_q <= '0;
         aop2_q <= '0;
         for (int i = 0; i < 4; i++) begin
            pst_q[i]    <= P_IDLE;
            pcmd_q[i]   <= 4'd0;
            pop1_q[i]   <= '0;
            pop2_q[i]   <= '0;
            prcode_q[i] <= 2'd0;
            prdata_q[i] <= '0;
         end
      end else begin
         dst_q  <= dst_d;
         ptr_q  <= ptr_d;
         gnt_q  <= gnt_d;
         cnt_q  <= cnt_d;
         acmd_q <= acmd_d;
         aop1_q <= aop1_d;
         aop2_q <= aop2_d;
         for (int i = 0; i < 4; i++) begin
            pst_q[i]    <= pst_d[i];
            pcmd_q[i]   <= pcmd_d[i];
            pop1_q[i]   <= pop1_d[i];
            pop2_q[i]   <= pop2_d[i];
            prcode_q[i] <= prcode_d[i];
            prdata_q[i] <= prdata_d[i];
         end
      end
   end

   logic [1:0]        resp_w [4];
   logic [DATA_W-1:0] rdata_w [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         resp_w[i]  = 2'd0;
         rdata_w[i] = '0;
         if (pst_q[i] == P_RESP) begin
            resp_w[i]  = prcode_q[i];
            rdata_w[i] = prdata_q[i];
         end
      end
   end

   assign out1_resp = resp_w[0];
   assign out2_resp = resp_w[1];
   assign out3_resp = resp_w[2];
   assign out4_resp = resp_w[3];
   assign out1_data = rdata_w[0];
   assign out2_data = rdata_w[1];
   assign out3_data = rdata_w[2];
   assign out4_data = rdata_w[3];

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Scoreboard bench for calc_port_scheduler: a single process drives ports and the ALU model,
// predicts grants/responses from the round-robin and calc rules, and checks every output.
module tb_calc_port_scheduler;
   localparam int DW = 32;
   localparam int TO = 16;

   logic c_clk = 1'b0;
   logic reset = 1'b1;
   always #5 c_clk = ~c_clk;

   logic [3:0]    cmd_a  [4];
   logic [DW-1:0] dat_a  [4];
   logic [1:0]    resp_a [4];
   logic [DW-1:0] odat_a [4];
   logic          alu_valid;
   logic [3:0]    alu_cmd;
   logic [DW-1:0] alu_op1, alu_op2;
   logic          alu_done   = 1'b0;
   logic [1:0]    alu_resp   = 2'd0;
   logic [DW-1:0] alu_result = '0;

   calc_port_scheduler #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .c_clk(c_clk), .reset(reset),
      .req1_cmd_in(cmd_a[0]), .req2_cmd_in(cmd_a[1]), .req3_cmd_in(cmd_a[2]), .req4_cmd_in(cmd_a[3]),
      .req1_data_in(dat_a[0]), .req2_data_in(dat_a[1]), .req3_data_in(dat_a[2]), .req4_data_in(dat_a[3]),
      .out1_resp(resp_a[0]), .out2_resp(resp_a[1]), .out3_resp(resp_a[2]), .out4_resp(resp_a[3]),
      .out1_data(odat_a[0]), .out2_data(odat_a[1]), .out3_data(odat_a[2]), .out4_data(odat_a[3]),
      .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_done(alu_done), .alu_resp(alu_resp), .alu_result(alu_result)
   );

   typedef struct {
      int            port;
      logic [1:0]    resp;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   epoch = 0;
   bit   pending [4];
   int   pend_cyc [4];
   bit   free_p [4];
   bit   op2_pend [4];
   logic [DW-1:0] op2_val [4];
   logic [3:0]    rq_cmd [4];
   logic [DW-1:0] rq_op1 [4];
   logic [DW-1:0] rq_op2 [4];
   int   rr = 0;
   int   busy_until = 0;
   bit   done_pend = 0;
   int   done_at = 0, done_port = 0, done_ep = 0;
   int   v_log[$];
   int   g_log[$];
   int   alu_lat = 2;
   bit   force_to = 0;
   bit   rand_mode = 0;
   bit   zero_req = 0;

   function automatic bit cmd_valid(input logic [3:0] c);
      return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
   endfunction

   // Reference calculator: add/sub flag carry/borrow as code 2, shifts always succeed.
   function automatic void alu_ref(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   output logic [1:0] code, output logic [DW-1:0] res);
      logic [DW:0] w;
      code = 2'd1;
      res  = '0;
      case (c)
         4'd1: begin
            w   = {1'b0, a} + {1'b0, b};
            res = w[DW-1:0];
            if (w[DW]) code = 2'd2;
         end
         4'd2: begin
            res = a - b;
            if (a < b) code = 2'd2;
         end
         4'd5:    res = a << b[4:0];
         4'd6:    res = a >> b[4:0];
         default: code = 2'd2;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic sample();
      int  g;
      int  p;
      int  idx;
      int  lat;
      bit  idle;
      bit  to;
      exp_t e;
      logic [1:0]    code;
      logic [DW-1:0] res;
      idle = 1'b0;
      if (!reset) begin
         if (zero_req) begin
            zero_req = 0;
            for (int i = 0; i < 4; i++) begin
               chk($sformatf("post-reset out%0d", i + 1), {resp_a[i], odat_a[i]}, 64'd0);
            end
            chk("post-reset alu bus", {alu_valid, alu_cmd, alu_op1, alu_op2}, 64'd0);
         end
         for (int q = 0; q < 4; q++) begin
            if (resp_a[q] != 2'd0) begin
               idx = -1;
               for (int i = 0; i < sb.size(); i++) begin
                  if (idx < 0 && sb[i].port == q) idx = i;
               end
               if (idx < 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected response port%0d: got resp %0d data %0h expected none (cycle %0d)",
                           q + 1, resp_a[q], odat_a[q], cyc);
               end else begin
                  e = sb[idx];
                  sb.delete(idx);
                  chk($sformatf("port%0d resp", q + 1), 64'(resp_a[q]), 64'(e.resp));
                  chk($sformatf("port%0d data", q + 1), 64'(odat_a[q]), 64'(e.data));
                  chk($sformatf("port%0d resp cycle", q + 1), 64'(cyc), 64'(e.cyc));
                  free_p[q] = 1;
               end
            end else begin
               chk($sformatf("port%0d idle data", q + 1), 64'(odat_a[q]), 64'd0);
            end
         end
         g = -1;
         for (int k = 0; k < 4; k++) begin
            p = (rr + k) % 4;
            if (g < 0 && pending[p] && pend_cyc[p] <= cyc) g = p;
         end
         idle = (cyc > busy_until);
         if (alu_valid) begin
            chk("dispatch while busy", 64'(idle), 64'd1);
            if (g < 0) begin
               checks++;
               failures++;
               $display("FAIL dispatch with no pending port: got cmd %0h expected no alu_valid (cycle %0d)", alu_cmd, cyc);
            end else begin
               chk($sformatf("grant port%0d cmd", g + 1), 64'(alu_cmd), 64'(rq_cmd[g]));
               chk($sformatf("grant port%0d op1", g + 1), 64'(alu_op1), 64'(rq_op1[g]));
               chk($sformatf("grant port%0d op2", g + 1), 64'(alu_op2), 64'(rq_op2[g]));
               pending[g] = 0;
               rr = (g + 1) % 4;
               v_log.push_back(cyc);
               g_log.push_back(g);
               to = rand_mode ? ($urandom_range(0, 9) == 0) : force_to;
               force_to = 0;
               if (to) begin
                  sb.push_back('{g, 2'd3, '0, cyc + TO + 1});
                  busy_until = cyc + TO;
               end else begin
                  lat = rand_mode ? int'($urandom_range(1, 5)) : alu_lat;
                  done_pend = 1;
                  done_at = cyc + lat;
                  done_port = g;
                  done_ep = epoch;
                  busy_until = cyc + lat;
               end
            end
         end else if (idle && g >= 0) begin
            checks++;
            failures++;
            $display("FAIL missed dispatch port%0d: got no alu_valid expected grant (cycle %0d)", g + 1, cyc);
         end
      end
      alu_done = 1'b0;
      if (done_pend && cyc == done_at) begin
         done_pend = 0;
         alu_ref(rq_cmd[done_port], rq_op1[done_port], rq_op2[done_port], code, res);
         alu_done = 1'b1;
         alu_resp = code;
         alu_result = res;
         if (done_ep == epoch) sb.push_back('{done_port, code, res, cyc + 1});
      end else if (rand_mode && idle && !reset && $urandom_range(0, 7) == 0) begin
         // stray completion while nothing is outstanding must be ignored
         alu_done = 1'b1;
         alu_resp = 2'($urandom_range(1, 2));
         alu_result = $urandom;
      end
   endtask

   task automatic tick();
      @(negedge c_clk);
      sample();
      @(posedge c_clk);
      cyc++;
      #1;
      for (int p = 0; p < 4; p++) begin
         if (op2_pend[p]) begin
            cmd_a[p] = 4'($urandom_range(0, 15));
            dat_a[p] = op2_val[p];
            op2_pend[p] = 0;
         end else begin
            cmd_a[p] = (rand_mode && !free_p[p] && $urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            dat_a[p] = $urandom;
         end
      end
   endtask

   task automatic issue(input int p, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
      cmd_a[p] = c;
      dat_a[p] = a;
      op2_pend[p] = 1;
      op2_val[p] = b;
      free_p[p] = 0;
      rq_cmd[p] = c;
      rq_op1[p] = a;
      rq_op2[p] = b;
      if (cmd_valid(c)) begin
         pending[p] = 1;
         pend_cyc[p] = cyc + 2;
      end else begin
         sb.push_back('{p, 2'd2, '0, cyc + 2});
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      epoch++;
      sb.delete();
      rr = 0;
      for (int p = 0; p < 4; p++) begin
         pending[p] = 0;
         free_p[p] = 1;
         op2_pend[p] = 0;
         cmd_a[p] = 4'd0;
      end
      repeat (n) tick();
      reset = 1'b0;
      busy_until = cyc - 1;
   endtask

   function automatic bit all_quiet();
      bit q;
      q = (sb.size() == 0);
      for (int p = 0; p < 4; p++) begin
         if (!free_p[p] || pending[p] || op2_pend[p]) q = 0;
      end
      return q;
   endfunction

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while (!all_quiet() && n < budget) begin
         tick();
         n++;
      end
      chk({name, " drained"}, 64'(n < budget), 64'd1);
      tick();
   endtask

   function automatic logic [DW-1:0] rand_data();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [3:0] rand_cmd();
      logic [3:0] c;
      case ($urandom_range(0, 9))
         0, 1:    c = 4'd1;
         2, 3:    c = 4'd2;
         4, 5:    c = 4'd5;
         6, 7:    c = 4'd6;
         default: begin
            c = 4'($urandom_range(3, 15));
            while (cmd_valid(c)) c = 4'($urandom_range(3, 15));
         end
      endcase
      return c;
   endfunction

   initial begin
      int t;
      int base;
      int n;
      bit re;
      for (int p = 0; p < 4; p++) begin
         cmd_a[p] = 4'd0;
         dat_a[p] = '0;
         free_p[p] = 1;
      end
      do_reset(3);
      zero_req = 1;
      tick();

      // add, two-cycle ALU
      t = cyc;
      issue(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
      wait_idle(100, "add");
      chk("add dispatch cycle", 64'(v_log[$]), 64'(t + 2));

      // sub with underflow passes code 2 through
      issue(1, 4'd2, 32'h1, 32'hF);
      wait_idle(100, "sub");

      // invalid cmd: no dispatch, response at T+2, new cmd accepted at T+3
      base = v_log.size();
      t = cyc;
      issue(2, 4'd3, 32'h1, 32'h0);
      tick();
      tick();
      tick();
      chk("invalid port free at T+3", 64'(free_p[2] && cyc == t + 3), 64'd1);
      issue(2, 4'd1, 32'h5, 32'h6);
      wait_idle(100, "invalid");
      chk("invalid dispatch count", 64'(v_log.size() - base), 64'd1);

      // four simultaneous requests, port 1 re-requests immediately
      do_reset(1);
      zero_req = 1;
      tick();
      base = g_log.size();
      for (int p = 0; p < 4; p++) issue(p, 4'd1, $urandom, $urandom);
      re = 0;
      n = 0;
      while (!(re && all_quiet()) && n < 200) begin
         tick();
         n++;
         if (!re && free_p[0]) begin
            issue(0, 4'd1, $urandom, $urandom);
            re = 1;
         end
      end
      chk("rr grant count", 64'(g_log.size() - base), 64'd5);
      if (g_log.size() - base == 5) begin
         for (int i = 0; i < 4; i++) chk($sformatf("rr grant %0d", i), 64'(g_log[base + i]), 64'(i));
         chk("rr wrap to port1", 64'(g_log[base + 4]), 64'd0);
      end
      tick();

      // timeout, then next pending port dispatched
      force_to = 1;
      base = v_log.size();
      issue(0, 4'd1, 32'h10, 32'h20);
      issue(1, 4'd5, 32'h3, 32'h4);
      wait_idle(200, "timeout");
      chk("timeout dispatch count", 64'(v_log.size() - base), 64'd2);
      if (v_log.size() - base == 2) chk("post-timeout dispatch gap", 64'(v_log[base + 1] - v_log[base]), 64'(TO + 1));

      // reset while one port waits and another is pending
      alu_lat = 8;
      base = v_log.size();
      issue(0, 4'd1, 32'h7, 32'h8);
      issue(1, 4'd2, 32'h9, 32'h1);
      n = 0;
      while (v_log.size() == base && n < 20) begin
         tick();
         n++;
      end
      chk("reset-test dispatch seen", 64'(v_log.size() > base), 64'd1);
      tick();
      tick();
      do_reset(1);
      zero_req = 1;
      repeat (12) tick();
      alu_lat = 2;
      issue(2, 4'd6, 32'hF0, 32'h4);
      wait_idle(100, "post-reset");

      // randomized traffic with noise cmds, stray completions and random timeouts
      rand_mode = 1;
      repeat (1500) begin
         tick();
         for (int p = 0; p < 4; p++) begin
            if (free_p[p] && !op2_pend[p] && $urandom_range(0, 2) == 0) issue(p, rand_cmd(), rand_data(), rand_data());
         end
      end
      rand_mode = 0;
      wait_idle(800, "random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
